// File: rtl/mcpu_pkg.sv
// Shared opcodes, FSM state encodings and instruction field layout for multicycle_cpu.
// No logic; constants and one constant function only.
// Not applicable (no handshakes).
package mcpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_ANDI = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_J    = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef logic [2:0] state_t;
    localparam state_t S_FETCH  = 3'd0;
    localparam state_t S_DECODE = 3'd1;
    localparam state_t S_EXEC   = 3'd2;
    localparam state_t S_WB     = 3'd3;
    localparam state_t S_HALT   = 3'd4;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam int FLD_OP = 0;
    localparam int FLD_RS = 1;
    localparam int FLD_RT = 2;
    localparam int FLD_RD = 3;

    // LSB position of a field; the immediate occupies everything below rt (overlapping rd).
    function automatic int field_lsb(input int data_w, input int reg_aw, input int fld);
        return data_w - 4 - fld * reg_aw;
    endfunction

endpackage

// File: rtl/mcpu_alu.sv
// Combinational ALU: ADD/SUB/AND/OR on a 2-bit function code, results modulo 2^DATA_W.
// Latency: zero (purely combinational).
// Backpressure: none.
module mcpu_alu
    import mcpu_pkg::*;
#(
    parameter int DATA_W = 19
) (
    input  logic [1:0]        func,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (func)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: FETCH/DECODE/EXEC/WB per instruction; MCPU_ZERO_REG_EN makes r0 hardwired zero.
// Latency: 4 cycles per instruction plus one per FETCH cycle without imem_valid.
// Backpressure: FETCH holds imem_req/imem_addr until imem_valid; HALT is terminal until reset.
module multicycle_cpu
    import mcpu_pkg::*;
#(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 5,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int RS_LSB = field_lsb(DATA_W, REG_AW, FLD_RS);
    localparam int RT_LSB = field_lsb(DATA_W, REG_AW, FLD_RT);
    localparam int RD_LSB = field_lsb(DATA_W, REG_AW, FLD_RD);
    localparam int IMM_W  = RT_LSB;
    localparam int NREG   = 1 << REG_AW;

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              br_taken;
    logic [DATA_W-1:0] rf [NREG];

    logic [3:0]        op;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] alu_y;
    logic [1:0]        alu_func;
    logic              is_rtype;
    logic              is_itype;
    logic [REG_AW-1:0] wr_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] pc_next;

    assign op      = ir[DATA_W-1 -: 4];
    assign rs      = ir[RS_LSB +: REG_AW];
    assign rt      = ir[RT_LSB +: REG_AW];
    assign rd      = ir[RD_LSB +: REG_AW];
    assign imm     = ir[IMM_W-1:0];
    assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_itype = (op == OP_ADDI) || (op == OP_ANDI);
    assign wr_addr  = is_rtype ? rd : rt;

    // Gated by reset so no request is ever visible while the core is held in reset.
    assign imem_req  = reset && (state == S_FETCH);
    assign imem_addr = pc;

    always_comb begin
        rs_val = rf[rs];
        rt_val = rf[rt];
`ifdef MCPU_ZERO_REG_EN
        if (rs == '0) rs_val = '0;
        if (rt == '0) rt_val = '0;
`endif
    end

`ifdef MCPU_ZERO_REG_EN
    assign wr_en = (state == S_WB) && (is_rtype || is_itype) && (wr_addr != '0);
`else
    assign wr_en = (state == S_WB) && (is_rtype || is_itype);
`endif

    always_comb begin
        alu_func = ALU_ADD;
        case (op)
            OP_SUB:          alu_func = ALU_SUB;
            OP_AND, OP_ANDI: alu_func = ALU_AND;
            OP_OR:           alu_func = ALU_OR;
            default:         alu_func = ALU_ADD;
        endcase
    end

    mcpu_alu #(.DATA_W(DATA_W)) u_alu (
        .func (alu_func),
        .a    (a_q),
        .b    (b_q),
        .y    (alu_y)
    );

    always_comb begin
        pc_next = pc + ADDR_W'(1);
        case (op)
            OP_BEQ:  if (br_taken) pc_next = pc + ADDR_W'(1) + imm_ext[ADDR_W-1:0];
            OP_J:    pc_next = imm[ADDR_W-1:0];
            OP_HALT: pc_next = pc;
            default: pc_next = pc + ADDR_W'(1);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            br_taken   <= 1'b0;
            alu_result <= '0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q   <= rs_val;
                    b_q   <= is_itype ? imm_ext : rt_val;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_rtype || is_itype) alu_result <= alu_y;
                    br_taken <= (op == OP_BEQ) && (a_q == b_q);
                    state    <= S_WB;
                end
                S_WB: begin
                    pc <= pc_next;
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[wr_addr] <= alu_result;
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed programs, expected fetches queued and checked by a fetch monitor.
module tb_multicycle_cpu;

    localparam int DW  = 19;
    localparam int AW  = 5;
    localparam logic [DW-1:0] HALT_W = {4'hF, 15'd0};
    localparam logic [DW-1:0] NOP_W  = {4'h8, 15'd0};
`ifdef MCPU_ZERO_REG_EN
    localparam logic [DW-1:0] ZR_EXP = 19'd0;
`else
    localparam logic [DW-1:0] ZR_EXP = 19'd14;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_valid;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] alu_result;
    logic [AW-1:0] pc;
    logic          halted;
    logic          valid_en = 1'b1;
    logic [DW-1:0] mem [32];

    always #5 clk = ~clk;

    assign imem_valid = valid_en;
    assign imem_rdata = mem[imem_addr];

    multicycle_cpu #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .alu_result (alu_result),
        .pc         (pc),
        .halted     (halted)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] alu;
        int            gap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] r_ins(input logic [3:0] op, input logic [2:0] rs,
                                            input logic [2:0] rt, input logic [2:0] rd);
        return {op, rs, rt, rd, 6'd0};
    endfunction

    function automatic logic [DW-1:0] i_ins(input logic [3:0] op, input logic [2:0] rs,
                                            input logic [2:0] rt, input logic [8:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [AW-1:0] addr, input logic [DW-1:0] alu, input int gap);
        exp_t x;
        x.addr = addr;
        x.alu  = alu;
        x.gap  = gap;
        q.push_back(x);
    endtask

    // Each accepted fetch is compared with the next queued expectation.
    always @(negedge clk) begin
        if (reset && imem_req && imem_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got addr %0d expected none", imem_addr);
            end else begin
                e = q.pop_front();
                chk("fetch_addr", 32'(imem_addr), 32'(e.addr));
                chk("alu_at_fetch", 32'(alu_result), 32'(e.alu));
                if (e.gap != 0) chk("fetch_gap", cyc - last_acc, e.gap);
            end
            last_acc = cyc;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = HALT_W;
    endtask

    task automatic do_reset(input logic ve);
        reset    = 1'b0;
        valid_en = ve;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_alu", 32'(alu_result), 0);
        chk("rst_halted", 32'(halted), 0);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic wait_halt(input int max);
        int n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("halt_reached", 32'(halted), 1);
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        // Basic ALU sequence with a negative immediate.
        clear_mem();
        mem[0] = i_ins(4'd4, 3'd0, 3'd1, 9'd5);
        mem[1] = i_ins(4'd4, 3'd0, 3'd2, 9'h1FD);
        mem[2] = r_ins(4'd0, 3'd1, 3'd2, 3'd3);
        do_reset(1'b1);
        push(0, 0, 0);
        push(1, 5, 4);
        push(2, 19'h7FFFD, 4);
        push(3, 2, 4);
        wait_halt(100);
        chk("t1_pc", 32'(pc), 3);

        // Three stalled fetch cycles; a word visible before valid must not be latched.
        clear_mem();
        mem[0] = i_ins(4'd4, 3'd0, 3'd1, 9'd9);
        do_reset(1'b0);
        push(0, 0, 0);
        push(1, 5, 4);
        repeat (3) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 1);
            chk("stall_addr", 32'(imem_addr), 0);
        end
        @(posedge clk);
        #1;
        mem[0]   = i_ins(4'd4, 3'd0, 3'd1, 9'd5);
        valid_en = 1'b1;
        @(negedge clk);
        chk("stall_req_last", 32'(imem_req), 1);
        @(negedge clk);
        chk("decode_req_low", 32'(imem_req), 0);
        wait_halt(100);

        // BEQ taken: 2+1+4 = 7.
        clear_mem();
        mem[0] = i_ins(4'd4, 3'd0, 3'd1, 9'd1);
        mem[1] = NOP_W;
        mem[2] = i_ins(4'd6, 3'd1, 3'd1, 9'd4);
        do_reset(1'b1);
        push(0, 0, 0);
        push(1, 1, 4);
        push(2, 1, 4);
        push(7, 1, 4);
        wait_halt(100);
        chk("beq_taken_pc", 32'(pc), 7);

        // BEQ not taken falls through to 3.
        mem[2] = i_ins(4'd6, 3'd1, 3'd2, 9'd4);
        do_reset(1'b1);
        push(0, 0, 0);
        push(1, 1, 4);
        push(2, 1, 4);
        push(3, 1, 4);
        wait_halt(100);
        chk("beq_fall_pc", 32'(pc), 3);

        // Jump to 31, NOP there wraps the pc back to 0.
        clear_mem();
        mem[0]  = i_ins(4'd7, 3'd0, 3'd0, 9'd31);
        mem[31] = NOP_W;
        do_reset(1'b1);
        push(0, 0, 0);
        push(31, 0, 4);
        push(0, 0, 4);
        wait_drain(100);

        // Register 0 behaviour depends on the build option.
        clear_mem();
        mem[0] = i_ins(4'd4, 3'd0, 3'd0, 9'd7);
        mem[1] = r_ins(4'd0, 3'd0, 3'd0, 3'd1);
        do_reset(1'b1);
        push(0, 0, 0);
        push(1, 7, 4);
        push(2, ZR_EXP, 4);
        wait_halt(100);

        // HALT at 4 holds, then an asynchronous reset clears it without a clock edge.
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = NOP_W;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) push(AW'(i), 0, (i == 0) ? 0 : 4);
        wait_halt(100);
        repeat (10) begin
            @(negedge clk);
            chk("halt_hold", 32'(halted), 1);
            chk("halt_req", 32'(imem_req), 0);
            chk("halt_pc", 32'(pc), 4);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_halted", 32'(halted), 0);
        chk("async_pc", 32'(pc), 0);
        chk("async_req", 32'(imem_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle core. Executes one instruction per pass of a FETCH/DECODE/EXEC/WB state machine and fetches from an external instruction memory over a request/valid handshake, so slow ROMs work. Adds branch, absolute jump and halt, with configurable datapath and register-file widths. Sits at the processor top level, between instruction memory and the debug/LED output.

## Interface
Parameters:
- DATA_W, 19: datapath, register and instruction width; must be ≥ 4+3·REG_AW+1.
- ADDR_W, 5: instruction address (PC) width.
- REG_AW, 3: register address width; the register file has 2^REG_AW entries.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; high exactly while state is FETCH.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- imem_valid  in  1  instruction data valid; sampled only while imem_req is high.
- imem_rdata  in  DATA_W  instruction word.
- alu_result  out  DATA_W  registered result of the last EXEC.
- pc  out  ADDR_W  current program counter.
- halted  out  1  high once HALT has retired.

## Operation
Instruction fields (IW=DATA_W):
- op: [IW-1:IW-4].
- rs: next REG_AW bits; rt: next REG_AW bits; rd: next REG_AW bits.
- imm: all bits below op, rs and rt (width IW-4-2·REG_AW); sign-extended to DATA_W.

Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR: rd ← rs op rt.
- 4 ADDI, 5 ANDI: rt ← rs op imm.
- 6 BEQ: if rs==rt then pc ← pc+1+imm; no register write.
- 7 J: pc ← imm[ADDR_W-1:0].
- 15 HALT: enter HALT.
- 8–14: NOP, with pc ← pc+1.

Arithmetic:
- All ALU results are modulo 2^DATA_W; no flags.
- All PC arithmetic is modulo 2^ADDR_W. pc=2^ADDR_W−1 plus 1 wraps to 0.
- For BEQ, imm is truncated to ADDR_W bits after sign extension.

States:
- FETCH: imem_req=1. On imem_valid=1, latch imem_rdata into IR and go to DECODE. Otherwise stay.
- DECODE: read rs and rt into operand registers A and B; select B or imm per op.
- EXEC: compute the ALU result into alu_result. For BEQ/J/HALT/NOP, alu_result holds its previous value. Evaluate the branch condition.
- WB: write rd/rt if the op writes. Update pc (+1, branch target or jump target). Go to FETCH, or to HALT for op 15 (pc is not advanced).
- HALT: terminal state with imem_req=0 and halted=1; left only by reset.

Register file:
- One write port, read in DECODE.
- Writes in WB are visible to the next instruction's DECODE.

Reset (reset low):
- Immediately forces state=FETCH, pc=0, alu_result=0, halted=0, IR=0 and all registers to 0.
- imem_req is held at 0 while reset is low.
- Reset mid-fetch abandons the request; a late imem_valid is ignored.

## Timing
- Minimum 4 cycles per instruction: FETCH with same-cycle valid, then DECODE, EXEC, WB. Each cycle imem_valid stays low adds one FETCH cycle.
- imem_req rises in the first clock after reset deasserts. imem_addr is stable for the whole FETCH.
- alu_result updates at the EXEC→WB edge; register write and pc update occur at the WB→FETCH edge.
- halted rises at the WB→HALT edge.
- imem_valid outside FETCH is a don't-care.

## Configuration
- MCPU_ZERO_REG_EN defined: register 0 reads as 0 and writes to it are discarded.
- Undefined: register 0 is an ordinary register.

## Structure
- Package mcpu_pkg holds:
  - opcode localparams (OP_ADD … OP_HALT);
  - state enum (S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT);
  - the field-offset function of DATA_W and REG_AW.
- One sub-module, mcpu_alu: combinational, parametrised by DATA_W, implementing ADD/SUB/AND/OR on a 2-bit function code.
- Register file and FSM stay in the top module.

## Test plan
Defaults unless stated; imem_valid is held high unless stated.
- Reset, then ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 → alu_result=2 after the third EXEC; pc=3 after its WB; each instruction takes 4 cycles.
- imem_valid held low for 3 cycles on the first fetch → imem_req high for 4 cycles with imem_addr=0; IR latches only on the valid cycle; total 7 cycles.
- BEQ r1,r1,+4 at pc=2 → next imem_addr=7. BEQ with unequal operands at pc=2 → next imem_addr=3.
- J 31, then a NOP at 31 → next fetch address 0 (wrap).
- HALT at pc=4 → halted=1, imem_req=0 and pc=4, held for 10 more cycles. Reset low asynchronously → halted=0 and pc=0 without a clock edge.
- ADDI r0,r0,7; ADD r1,r0,r0 → with MCPU_ZERO_REG_EN alu_result=0; without it alu_result=14.
